// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer around one shared N-bit adder.
// Walks the operands LSB slice first and chains the carry from slice to slice.
// Handshake: the operand is accepted in IDLE, the result is held in DONE until
// the consumer takes it.
module mp_add_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*K-1:0]   in_a,
    input  logic [N*K-1:0]   in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_ci,
    input  logic [N-1:0]     add_s,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*K-1:0]   out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int unsigned W  = N * K;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            a_msb;
    logic            b_msb;
    logic [W-1:0]    b_eff_c;

    // Subtraction feeds the one's complement of B; the +1 comes in as the first carry.
    assign b_eff_c = in_sub ? ~in_b : in_b;

    // Sequencer: adder inputs are registered one slice ahead, so add_ci is the chained carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            in_ready  <= 1'b1;
            add_a     <= '0;
            add_b     <= '0;
            add_ci    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        add_a    <= in_a[N-1:0];
                        add_b    <= b_eff_c[N-1:0];
                        add_ci   <= in_sub | in_ci;
                        a_sh     <= in_a >> N;
                        b_sh     <= b_eff_c >> N;
                        a_msb    <= in_a[W-1];
                        b_msb    <= b_eff_c[W-1];
                        idx      <= '0;
                        out_sum  <= '0;
                        out_co   <= 1'b0;
                        out_ovf  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum[int'(idx)*N +: N] <= add_s;
                    if (idx == LAST) begin
                        add_a     <= '0;
                        add_b     <= '0;
                        add_ci    <= 1'b0;
                        out_co    <= add_co;
                        out_ovf   <= (a_msb == b_msb) && (add_s[N-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        add_a  <= a_sh[N-1:0];
                        add_b  <= b_sh[N-1:0];
                        add_ci <= add_co;
                        a_sh   <= a_sh >> N;
                        b_sh   <= b_sh >> N;
                        idx    <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: randomized and directed checks of mp_add_seq (N=8, K=4)
// against an arithmetic reference model; the shared adder is modelled here.
module tb_mp_add_seq;

    localparam int unsigned N = 8;
    localparam int unsigned K = 4;
    localparam int unsigned W = N * K;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_ci = 1'b0;
    logic           in_sub = 1'b0;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic           add_ci;
    logic [N-1:0]   add_s;
    logic           add_co;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_sum;
    logic           out_co;
    logic           out_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared N-bit adder sitting next to the sequencer.
    assign {add_co, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_ci);

    mp_add_seq #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: unsigned result/carry and signed overflow from plain arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, output logic [W-1:0] sum, output logic co,
                         output logic ovf);
        longint unsigned ua, ub, ur;
        longint sa, sb, sr;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + 64'(ci);
            sr = sa + sb + longint'(ci);
            co = (ur >= 64'h1_0000_0000);
        end
        sum = W'(ur);
        ovf = (sr > SMAX) || (sr < SMIN);
    endtask

    // Carry entering slice i: carry out of the low i slices summed as one number.
    function automatic logic slice_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sub, input int i);
        longint unsigned bv, mask, t;
        logic c0;
        c0 = sub ? 1'b1 : ci;
        bv = sub ? 64'(~b) : 64'(b);
        if (i == 0) return c0;
        mask = (64'd1 << (N * i)) - 64'd1;
        t = (64'(a) & mask) + (bv & mask) + 64'(c0);
        return t[N*i];
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sub, input int stall, input string tag);
        logic [W-1:0] es, av, bv;
        logic eco, eov;
        int cnt;
        bit seen;
        model(a, b, ci, sub, es, eco, eov);
        av = a;
        bv = sub ? ~b : b;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_ci     = ci;
        in_sub    = sub;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_ci    = 1'($urandom);
        in_sub   = 1'($urandom);
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < K + 6) begin
            @(negedge clk);
            cnt++;
            if (out_valid) begin
                seen = 1'b1;
            end else if (cnt <= K) begin
                check({tag, " add_a"}, 64'(add_a), 64'(av[(cnt-1)*N +: N]));
                check({tag, " add_b"}, 64'(add_b), 64'(bv[(cnt-1)*N +: N]));
                check({tag, " add_ci"}, 64'(add_ci), 64'(slice_cin(a, b, ci, sub, cnt - 1)));
                check({tag, " in_ready run"}, 64'(in_ready), 64'd0);
            end
        end
        check({tag, " latency"}, 64'(cnt), 64'(K + 1));
        check({tag, " sum"}, 64'(out_sum), 64'(es));
        check({tag, " co"}, 64'(out_co), 64'(eco));
        check({tag, " ovf"}, 64'(out_ovf), 64'(eov));
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, " stall valid"}, 64'(out_valid), 64'd1);
                check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
                check({tag, " stall sum"}, 64'(out_sum), 64'(es));
                check({tag, " stall co"}, 64'(out_co), 64'(eco));
                check({tag, " stall ovf"}, 64'(out_ovf), 64'(eov));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        check({tag, " sum hold"}, 64'(out_sum), 64'(es));
        check({tag, " add_a idle"}, 64'(add_a), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state
        #12;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_sum", 64'(out_sum), 64'd0);
        check("rst add_a", 64'(add_a), 64'd0);
        check("rst add_b", 64'(add_b), 64'd0);
        check("rst add_ci", 64'(add_ci), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", 64'(in_ready), 64'd1);

        // Directed boundary cases
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_wrap");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, "sub_neg");
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, "sub_pos");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_povf");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, "add_novf");
        run_op(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 3, "add_stall");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2, "sub_ovf");

        // Reset while the third slice is in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'hA1B2_C3D4;
        in_b     = 32'h0102_0304;
        in_ci    = 1'b0;
        in_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun add_a", 64'(add_a), 64'h00B2);
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_sum", 64'(out_sum), 64'd0);
        check("midrst add_a", 64'(add_a), 64'd0);
        check("midrst add_ci", 64'(add_ci), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("postrst no valid", 64'(out_valid), 64'd0);
        end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, "post_rst");

        // Randomized operations
        for (int r = 0; r < 60; r++) begin
            logic [W-1:0] ra, rb;
            int st;
            ra = pick();
            rb = pick();
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(ra, rb, 1'($urandom), 1'($urandom), st, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
